// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: memory op codes, register-0 id and the
// layout of one commit-trace entry.
package wb_stage_pkg;

  localparam logic [7:0] MEMTYPE_LB  = 8'h01;
  localparam logic [7:0] MEMTYPE_LBU = 8'h02;
  localparam logic [7:0] MEMTYPE_LH  = 8'h03;
  localparam logic [7:0] MEMTYPE_LHU = 8'h04;
  localparam logic [7:0] MEMTYPE_LW  = 8'h05;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int TRACE_W = 32 + 4 + 5 + 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/wb_stage_trace_fifo.sv
// trace_fifo: two-write/one-read commit-trace queue. Pops one entry every cycle it is
// non-empty; pushes that do not fit are dropped (oldest kept) and flag a sticky overflow.
module trace_fifo
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push1_i,
  input  trace_entry_t             ent1_i,
  input  logic                     push2_i,
  input  trace_entry_t             ent2_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  output trace_entry_t             head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, wp2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [CW:0]   free;
  logic          pop, acc1, acc2;

  // The entry leaving this cycle frees its slot for a push in the same cycle.
  always_comb begin
    pop   = (cnt_q != '0);
    free  = (CW+1)'(DEPTH) - {1'b0, cnt_q} + {{CW{1'b0}}, pop};
    acc1  = push1_i && (free != '0);
    acc2  = push2_i && (acc1 ? (free >= (CW+1)'(2)) : (free != '0));
    wp2   = wp_q + AW'(acc1);
    wp_d  = wp_q + AW'(acc1) + AW'(acc2);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(acc1) + CW'(acc2) - CW'(pop);
    ovf_d = ovf_q | (push1_i && !acc1) | (push2_i && !acc2);
  end

  always_ff @(posedge clk) begin
    if (acc1) mem_q[wp_q] <= ent1_i;
    if (acc2) mem_q[wp2]  <= ent2_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign head_o  = pop ? mem_q[rp_q] : '0;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: dual-issue write-back (load extraction, GPR write arbitration, HI/LO, CP0
// pass-through). Commit trace FIFO is built only when TRACE_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  wb_inst1_memtype,
  input  logic        wb_inst1_mreg,
  input  logic [1:0]  wb_inst1_whilo,
  input  logic        wb_inst1_wreg,
  input  logic [4:0]  wb_inst1_wa,
  input  logic [63:0] wb_inst1_hilo,
  input  logic [31:0] wb_inst1_w2regdata,
  input  logic [7:0]  wb_inst2_memtype,
  input  logic        wb_inst2_mreg,
  input  logic [1:0]  wb_inst2_whilo,
  input  logic        wb_inst2_wreg,
  input  logic [4:0]  wb_inst2_wa,
  input  logic [63:0] wb_inst2_hilo,
  input  logic [31:0] wb_inst2_w2regdata,
  input  logic [31:0] wb_iaddr1,
  input  logic [31:0] wb_iaddr2,
  input  logic [31:0] wb_daddr,
  input  logic [31:0] dm_rdata,
  input  logic        wb_wc0,
  input  logic [4:0]  wb_cp0addr,
  input  logic [31:0] wb_cp0wdata,
  output logic        rf_we1,
  output logic [4:0]  rf_wa1,
  output logic [31:0] rf_wd1,
  output logic        rf_we2,
  output logic [4:0]  rf_wa2,
  output logic [31:0] rf_wd2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        stallreq_o,
  output logic        trace_ovf,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  function automatic logic [31:0] load_extract(input logic [7:0]  mt,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rd[31:16] : rd[15:0];
    case (mt)
      MEMTYPE_LB:  return {{24{b[7]}}, b};
      MEMTYPE_LBU: return {24'd0, b};
      MEMTYPE_LH:  return {{16{h[15]}}, h};
      MEMTYPE_LHU: return {16'd0, h};
      MEMTYPE_LW:  return rd;
      default:     return 32'd0;
    endcase
  endfunction

  logic        we1_raw;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        unused_daddr;

  assign unused_daddr = ^wb_daddr[31:2];

  assign rf_wa1  = wb_inst1_wa;
  assign rf_wa2  = wb_inst2_wa;
  assign rf_wd1  = wb_inst1_mreg ? load_extract(wb_inst1_memtype, wb_daddr[1:0], dm_rdata)
                                 : wb_inst1_w2regdata;
  assign rf_wd2  = wb_inst2_mreg ? load_extract(wb_inst2_memtype, wb_daddr[1:0], dm_rdata)
                                 : wb_inst2_w2regdata;
  assign we1_raw = wb_inst1_wreg && (wb_inst1_wa != REG_ZERO);
  assign rf_we2  = wb_inst2_wreg && (wb_inst2_wa != REG_ZERO);
  // Slot 2 is younger: a same-register pair keeps only its write.
  assign rf_we1  = we1_raw && !(rf_we2 && (wb_inst1_wa == wb_inst2_wa));

  assign cp0_we    = wb_wc0;
  assign cp0_waddr = wb_cp0addr;
  assign cp0_wdata = wb_cp0wdata;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_inst1_whilo[1]) hi_d = wb_inst1_hilo[63:32];
    if (wb_inst1_whilo[0]) lo_d = wb_inst1_hilo[31:0];
    if (wb_inst2_whilo[1]) hi_d = wb_inst2_hilo[63:32];
    if (wb_inst2_whilo[0]) lo_d = wb_inst2_hilo[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

`ifdef TRACE_EN
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic [CW-1:0] trace_cnt;
  trace_entry_t  ent1, ent2, head;

  assign ent1 = '{pc: wb_iaddr1, wen: {4{rf_we1}}, wnum: wb_inst1_wa, wdata: rf_wd1};
  assign ent2 = '{pc: wb_iaddr2, wen: {4{rf_we2}}, wnum: wb_inst2_wa, wdata: rf_wd2};

  trace_fifo #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clk     (clk),
    .resetn  (resetn),
    .push1_i (wb_iaddr1 != 32'd0),
    .ent1_i  (ent1),
    .push2_i (wb_iaddr2 != 32'd0),
    .ent2_i  (ent2),
    .count_o (trace_cnt),
    .ovf_o   (trace_ovf),
    .head_o  (head)
  );

  // Threshold leaves room for the two pairs already in flight when the stall lands.
  assign stallreq_o        = (trace_cnt >= CW'(TRACE_DEPTH - 4));
  assign debug_wb_pc       = head.pc;
  assign debug_wb_rf_wen   = head.wen;
  assign debug_wb_rf_wnum  = head.wnum;
  assign debug_wb_rf_wdata = head.wdata;
`else
  logic unused_trace;
  assign unused_trace      = ^{wb_iaddr1, wb_iaddr2, (TRACE_DEPTH > 0)};
  assign stallreq_o        = 1'b0;
  assign trace_ovf         = 1'b0;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, HI/LO and trace corner sequences, and a
// randomized run against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 8;
`ifdef TRACE_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  wb_inst1_memtype, wb_inst2_memtype;
  logic        wb_inst1_mreg, wb_inst2_mreg;
  logic [1:0]  wb_inst1_whilo, wb_inst2_whilo;
  logic        wb_inst1_wreg, wb_inst2_wreg;
  logic [4:0]  wb_inst1_wa, wb_inst2_wa;
  logic [63:0] wb_inst1_hilo, wb_inst2_hilo;
  logic [31:0] wb_inst1_w2regdata, wb_inst2_w2regdata;
  logic [31:0] wb_iaddr1, wb_iaddr2, wb_daddr, dm_rdata;
  logic        wb_wc0;
  logic [4:0]  wb_cp0addr;
  logic [31:0] wb_cp0wdata;
  logic        rf_we1, rf_we2;
  logic [4:0]  rf_wa1, rf_wa2;
  logic [31:0] rf_wd1, rf_wd2, hi_o, lo_o;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        stallreq_o, trace_ovf;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  wb_stage #(.TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .wb_inst1_memtype(wb_inst1_memtype), .wb_inst1_mreg(wb_inst1_mreg),
    .wb_inst1_whilo(wb_inst1_whilo), .wb_inst1_wreg(wb_inst1_wreg),
    .wb_inst1_wa(wb_inst1_wa), .wb_inst1_hilo(wb_inst1_hilo),
    .wb_inst1_w2regdata(wb_inst1_w2regdata),
    .wb_inst2_memtype(wb_inst2_memtype), .wb_inst2_mreg(wb_inst2_mreg),
    .wb_inst2_whilo(wb_inst2_whilo), .wb_inst2_wreg(wb_inst2_wreg),
    .wb_inst2_wa(wb_inst2_wa), .wb_inst2_hilo(wb_inst2_hilo),
    .wb_inst2_w2regdata(wb_inst2_w2regdata),
    .wb_iaddr1(wb_iaddr1), .wb_iaddr2(wb_iaddr2), .wb_daddr(wb_daddr),
    .dm_rdata(dm_rdata), .wb_wc0(wb_wc0), .wb_cp0addr(wb_cp0addr),
    .wb_cp0wdata(wb_cp0wdata),
    .rf_we1(rf_we1), .rf_wa1(rf_wa1), .rf_wd1(rf_wd1),
    .rf_we2(rf_we2), .rf_wa2(rf_wa2), .rf_wd2(rf_wd2),
    .hi_o(hi_o), .lo_o(lo_o),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .stallreq_o(stallreq_o), .trace_ovf(trace_ovf),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } tent_t;

  tent_t       q[$];
  bit          m_ovf;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Load result from plain arithmetic on the byte/half index.
  function automatic logic [31:0] ref_load(input logic [7:0] mt, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned bsel;
    longint      bv, hv, v;
    bsel = addr % 4;
    bv   = longint'((rd >> (8 * bsel)) % 256);
    hv   = longint'((rd >> (16 * (bsel / 2))) % 65536);
    case (mt)
      8'h01: begin v = bv; if (v >= 128) v = v - 256; end
      8'h02: v = bv;
      8'h03: begin v = hv; if (v >= 32768) v = v - 65536; end
      8'h04: v = hv;
      8'h05: v = longint'(rd);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    wb_inst1_memtype = 0; wb_inst1_mreg = 0; wb_inst1_whilo = 0; wb_inst1_wreg = 0;
    wb_inst1_wa = 0; wb_inst1_hilo = 0; wb_inst1_w2regdata = 0;
    wb_inst2_memtype = 0; wb_inst2_mreg = 0; wb_inst2_whilo = 0; wb_inst2_wreg = 0;
    wb_inst2_wa = 0; wb_inst2_hilo = 0; wb_inst2_w2regdata = 0;
    wb_iaddr1 = 0; wb_iaddr2 = 0; wb_daddr = 0; dm_rdata = 0;
    wb_wc0 = 0; wb_cp0addr = 0; wb_cp0wdata = 0;
  endtask

  // Called at a negedge with inputs applied: checks every output, then advances the model
  // across the next rising edge and returns at the following negedge.
  task automatic step();
    logic e1, e2;
    logic [31:0] d1, d2;
    tent_t h;
    e2 = wb_inst2_wreg && (wb_inst2_wa != 0);
    e1 = wb_inst1_wreg && (wb_inst1_wa != 0) && !(e2 && wb_inst1_wa == wb_inst2_wa);
    d1 = wb_inst1_mreg ? ref_load(wb_inst1_memtype, wb_daddr, dm_rdata) : wb_inst1_w2regdata;
    d2 = wb_inst2_mreg ? ref_load(wb_inst2_memtype, wb_daddr, dm_rdata) : wb_inst2_w2regdata;
    #1;
    chk("rf_we1", 64'(rf_we1), 64'(e1));
    chk("rf_we2", 64'(rf_we2), 64'(e2));
    chk("rf_wa1", 64'(rf_wa1), 64'(wb_inst1_wa));
    chk("rf_wa2", 64'(rf_wa2), 64'(wb_inst2_wa));
    chk("rf_wd1", 64'(rf_wd1), 64'(d1));
    chk("rf_wd2", 64'(rf_wd2), 64'(d2));
    chk("cp0", {cp0_we, cp0_waddr, cp0_wdata}, {wb_wc0, wb_cp0addr, wb_cp0wdata});
    chk("hi_o", 64'(hi_o), 64'(m_hi));
    chk("lo_o", 64'(lo_o), 64'(m_lo));
    h = '0;
    if (TEN && q.size() > 0) h = q[0];
    chk("debug_wb_pc", 64'(debug_wb_pc), 64'(h.pc));
    chk("debug_wb_rf_wen", 64'(debug_wb_rf_wen), 64'(h.wen));
    chk("debug_wb_rf_wnum", 64'(debug_wb_rf_wnum), 64'(h.wnum));
    chk("debug_wb_rf_wdata", 64'(debug_wb_rf_wdata), 64'(h.wdata));
    chk("stallreq_o", 64'(stallreq_o), 64'(TEN && q.size() >= DEPTH - 4));
    chk("trace_ovf", 64'(trace_ovf), 64'(TEN && m_ovf));
    @(posedge clk);
    if (!resetn) begin
      q.delete(); m_ovf = 0; m_hi = 0; m_lo = 0;
    end else begin
      if (wb_inst1_whilo[1]) m_hi = wb_inst1_hilo[63:32];
      if (wb_inst1_whilo[0]) m_lo = wb_inst1_hilo[31:0];
      if (wb_inst2_whilo[1]) m_hi = wb_inst2_hilo[63:32];
      if (wb_inst2_whilo[0]) m_lo = wb_inst2_hilo[31:0];
      if (q.size() > 0) void'(q.pop_front());
      if (wb_iaddr1 != 0) begin
        if (q.size() < DEPTH) q.push_back('{wb_iaddr1, e1 ? 4'hF : 4'h0, wb_inst1_wa, d1});
        else m_ovf = 1;
      end
      if (wb_iaddr2 != 0) begin
        if (q.size() < DEPTH) q.push_back('{wb_iaddr2, e2 ? 4'hF : 4'h0, wb_inst2_wa, d2});
        else m_ovf = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs(input bit allow_push);
    wb_inst1_memtype = 8'($urandom_range(0, 6)); wb_inst2_memtype = 8'($urandom_range(0, 6));
    wb_inst1_mreg = 1'($urandom); wb_inst2_mreg = 1'($urandom);
    wb_inst1_whilo = 2'($urandom); wb_inst2_whilo = 2'($urandom);
    wb_inst1_wreg = 1'($urandom); wb_inst2_wreg = 1'($urandom);
    wb_inst1_wa = 5'($urandom_range(0, 3)); wb_inst2_wa = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) wb_inst2_wa = 5'($urandom);
    wb_inst1_hilo = {$urandom, $urandom}; wb_inst2_hilo = {$urandom, $urandom};
    wb_inst1_w2regdata = $urandom; wb_inst2_w2regdata = $urandom;
    wb_daddr = $urandom; dm_rdata = $urandom;
    wb_wc0 = 1'($urandom); wb_cp0addr = 5'($urandom); wb_cp0wdata = $urandom;
    wb_iaddr1 = (allow_push && $urandom_range(0, 3) != 0) ? ($urandom | 32'h1) : 32'd0;
    wb_iaddr2 = (allow_push && $urandom_range(0, 3) != 0) ? ($urandom | 32'h1) : 32'd0;
  endtask

  typedef struct {
    logic [7:0]  mt1;  logic mreg1; logic wreg1; logic [4:0] wa1; logic [31:0] alu1;
    logic [7:0]  mt2;  logic mreg2; logic wreg2; logic [4:0] wa2; logic [31:0] alu2;
    logic [31:0] daddr; logic [31:0] rdata;
    logic        ewe1; logic [31:0] ewd1; logic ewe2; logic [31:0] ewd2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h01, 1, 1, 3, 0,  8'h00, 0, 1, 4, 32'h55, 32'h101, 32'h1234_80FF,
                1, 32'hFFFF_FF80, 1, 32'h55};
    vecs[1] = '{8'h02, 1, 1, 3, 0,  8'h00, 0, 0, 4, 0, 32'h101, 32'h1234_80FF,
                1, 32'h0000_0080, 0, 0};
    vecs[2] = '{8'h04, 1, 1, 7, 0,  8'h00, 0, 0, 0, 0, 32'h202, 32'h1234_80FF,
                1, 32'h0000_1234, 0, 0};
    vecs[3] = '{8'h03, 1, 1, 7, 0,  8'h00, 0, 0, 0, 0, 32'h200, 32'h1234_80FF,
                1, 32'hFFFF_80FF, 0, 0};
    vecs[4] = '{8'h00, 0, 1, 9, 32'h77, 8'h05, 1, 1, 10, 0, 32'h300, 32'hDEAD_BEEF,
                1, 32'h77, 1, 32'hDEAD_BEEF};
    vecs[5] = '{8'h00, 0, 1, 5, 11, 8'h00, 0, 1, 5, 22, 32'h0, 32'h0,
                0, 11, 1, 22};
    vecs[6] = '{8'h00, 0, 1, 0, 11, 8'h00, 0, 1, 0, 22, 32'h0, 32'h0,
                0, 11, 0, 22};
    vecs[7] = '{8'h07, 1, 1, 2, 0,  8'h00, 0, 1, 3, 9, 32'h0, 32'hFFFF_FFFF,
                1, 0, 1, 9};
    vecs[8] = '{8'h01, 1, 1, 2, 0,  8'h02, 1, 1, 3, 0, 32'h403, 32'h9234_80FF,
                1, 32'hFFFF_FF92, 1, 32'h92};

    m_hi = 0; m_lo = 0; m_ovf = 0;
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    step();
    wb_inst1_whilo = 2'b11; wb_inst1_hilo = 64'h1111_2222_3333_4444;
    wb_iaddr1 = 32'h40; wb_iaddr2 = 32'h44;
    step();
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_pc", 64'(debug_wb_pc), 64'd0);
    resetn = 1;
    idle_inputs();

    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      wb_inst1_memtype = vecs[i].mt1; wb_inst1_mreg = vecs[i].mreg1;
      wb_inst1_wreg = vecs[i].wreg1; wb_inst1_wa = vecs[i].wa1;
      wb_inst1_w2regdata = vecs[i].alu1;
      wb_inst2_memtype = vecs[i].mt2; wb_inst2_mreg = vecs[i].mreg2;
      wb_inst2_wreg = vecs[i].wreg2; wb_inst2_wa = vecs[i].wa2;
      wb_inst2_w2regdata = vecs[i].alu2;
      wb_daddr = vecs[i].daddr; dm_rdata = vecs[i].rdata;
      wb_iaddr1 = 32'h1000 + 32'(i * 8);
      #1;
      chk($sformatf("vec%0d_we1", i), 64'(rf_we1), 64'(vecs[i].ewe1));
      chk($sformatf("vec%0d_wd1", i), 64'(rf_wd1), 64'(vecs[i].ewd1));
      chk($sformatf("vec%0d_we2", i), 64'(rf_we2), 64'(vecs[i].ewe2));
      chk($sformatf("vec%0d_wd2", i), 64'(rf_wd2), 64'(vecs[i].ewd2));
      step();
    end

    idle_inputs();
    wb_inst1_whilo = 2'b11; wb_inst1_hilo = {32'd1, 32'd2};
    wb_inst2_whilo = 2'b01; wb_inst2_hilo = {32'd3, 32'd4};
    step();
    chk("hilo_hi", 64'(hi_o), 64'd1);
    chk("hilo_lo", 64'(lo_o), 64'd4);
    idle_inputs();
    for (int i = 0; i < 6; i++) step();

    for (int i = 0; i < 400; i++) begin
      rand_inputs(q.size() < DEPTH - 4);
      step();
    end

    idle_inputs();
    resetn = 0;
    step();
    resetn = 1;
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      wb_iaddr1 = 32'h100 + 32'(i * 8); wb_iaddr2 = 32'h104 + 32'(i * 8);
      wb_inst1_wreg = 1; wb_inst1_wa = 5'(i + 1); wb_inst1_w2regdata = 32'(i);
      wb_inst2_wreg = 1; wb_inst2_wa = 5'(i + 11); wb_inst2_w2regdata = 32'(i + 100);
      step();
      if (i == 0) chk("first_pop_pc", 64'(debug_wb_pc), TEN ? 64'h100 : 64'd0);
      if (i == 1) chk("second_pop_pc", 64'(debug_wb_pc), TEN ? 64'h104 : 64'd0);
      if (i == 1) chk("stall_at_3", 64'(stallreq_o), 64'd0);
      if (i == 2) chk("stall_at_4", 64'(stallreq_o), TEN ? 64'd1 : 64'd0);
      if (i == 6) chk("ovf_before_drop", 64'(trace_ovf), 64'd0);
      if (i == 7) chk("ovf_first_drop", 64'(trace_ovf), TEN ? 64'd1 : 64'd0);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    chk("queued_five", 64'(q.size()), TEN ? 64'd5 : 64'd5);
    wb_iaddr1 = 32'h900; wb_iaddr2 = 32'h904;
    resetn = 0;
    step();
    chk("rst_drain_pc", 64'(debug_wb_pc), 64'd0);
    chk("rst_drain_ovf", 64'(trace_ovf), 64'd0);
    chk("rst_drain_stall", 64'(stallreq_o), 64'd0);
    resetn = 1;
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the dual-issue pipeline, fed every cycle by the MEM/WB pipeline register. It performs load-data extraction and register-file write arbitration, and owns the architectural HI/LO registers. It also forwards CP0 writes, and serialises up to two retired instructions per cycle onto the single-commit debug trace port.

## Interface
Parameters:
- TRACE_DEPTH, 8: trace FIFO entries; power of two, ≥ 8.

Ports (k = 1, 2; one line per signal per slot):
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- wb_instk_memtype  in  8  memory op code, values in package
- wb_instk_mreg  in  1  slot k result comes from memory
- wb_instk_whilo  in  2  [1] write HI, [0] write LO
- wb_instk_wreg  in  1  GPR write enable
- wb_instk_wa  in  5  GPR address
- wb_instk_hilo  in  64  {HI, LO} value
- wb_instk_w2regdata  in  32  ALU result
- wb_iaddrk  in  32  PC; 0 = bubble
- wb_daddr  in  32  data address of the (single) memory op of the pair
- dm_rdata  in  32  synchronous data-RAM read word
- wb_wc0 / wb_cp0addr / wb_cp0wdata  in  1/5/32  CP0 write request
- rf_wek / rf_wak / rf_wdk  out  1/5/32  GPR write port k
- hi_o, lo_o  out  32  architectural HI/LO
- cp0_we / cp0_waddr / cp0_wdata  out  1/5/32  CP0 write
- stallreq_o  out  1  trace back-pressure to the pipeline controller
- trace_ovf  out  1  sticky trace overflow
- debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  commit trace

## Operation
- Load extraction for slot with mreg=1, byte offset b = wb_daddr[1:0]:
  - LB/LBU: dm_rdata[8b+7:8b], sign- or zero-extended.
  - LH/LHU: half selected by wb_daddr[1], sign- or zero-extended.
  - LW: whole word.
  - Any other memtype: 0.
- rf_wdk = mreg ? extracted : w2regdata. rf_wek = wreg && wa≠0.
- Same-address dual write: when wa1==wa2 and both enabled, rf_we1 is forced 0. Slot 2 is younger and wins.
- HI/LO update: each half is written from the youngest slot whose whilo bit is set. Slot 2 beats slot 1.
- CP0 outputs are a direct copy of the wb_wc0/cp0 inputs.
- Trace capture:
  - Each slot with iaddr≠0 pushes {pc, wen = {4{rf_wek}}, wa, rf_wdk}.
  - Slot 1 is pushed before slot 2.
  - One entry is popped per cycle whenever the FIFO is non-empty. The debug port has no back-pressure.
  - Empty FIFO → debug outputs all 0.
- stallreq_o = count ≥ TRACE_DEPTH−4. This covers two pairs in flight after assertion.
- Overflow: pushes beyond free space are dropped, oldest entries are kept, and trace_ovf sets. trace_ovf clears only on reset.

## Timing
- rf_*, cp0_*: combinational, same cycle as the inputs.
- hi_o/lo_o: updated at the clock edge ending the WB cycle.
- Trace latency:
  - An entry pushed at edge N appears on debug_* in cycle N+1 at the earliest.
  - Slot 2 appears one cycle after slot 1.
- Push 2 + pop 1 → count+1. Push 1 + pop 1 → unchanged. Pointers wrap modulo TRACE_DEPTH.
- Reset (including mid-drain): FIFO empty, count 0, trace_ovf 0, hi_o = lo_o = 0, debug_* 0, stallreq_o 0. Inputs arriving in the reset cycle are ignored.

## Configuration
- TRACE_EN defined: trace FIFO, stallreq_o, trace_ovf and debug_* behave as above.
- TRACE_EN undefined: no FIFO is instantiated; stallreq_o, trace_ovf and all debug_* are tied to 0. Load extraction, GPR, HI/LO and CP0 behaviour are unchanged.

## Structure
- Shared package:
  - MEMTYPE_LB=8'h01, LBU=8'h02, LH=8'h03, LHU=8'h04, LW=8'h05.
  - Trace entry width, 32+4+5+32 = 73.
  - Register-0 constant.
- Sub-module trace_fifo: 2-write/1-read FIFO, parameter DEPTH. Outputs count, overflow and the head entry.

## Test plan
- LB, daddr=…01, dm_rdata=32'h1234_80FF → rf_wd1=32'hFFFF_FF80. Same with LBU → 32'h0000_0080.
- LHU, daddr=…10, dm_rdata=32'h1234_80FF → 32'h0000_1234. LH, daddr=…00 → 32'hFFFF_80FF.
- Both slots wreg, wa=5, w2regdata 11/22 → rf_we1=0, rf_we2=1, rf_wd2=22. wa=0 → no write.
- Slot1 whilo=11 with {1,2}, slot2 whilo=01 with {3,4} → next cycle hi_o=1, lo_o=4.
- Ten consecutive dual-valid pairs from reset (TRACE_DEPTH=8) → stallreq_o rises when count reaches 4. Pops continue in PC order with slot 1 before slot 2. trace_ovf sets on the first dropped push.
- Reset asserted with 5 entries queued → next cycle debug_wb_pc=0, FIFO empty, trace_ovf=0.
